// File: rtl/cal_div_multi_pkg.sv
// Shared definitions for the multi-channel calibration tone divider.
package cal_div_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NCH_DEF = 4;
  localparam int CW_DEF  = 16;
  localparam int BW_DEF  = 8;

endpackage

// File: rtl/cal_div_chan.sv
// One divider channel: half-period counter, square-wave toggle, burst period counter.
module cal_div_chan #(
  parameter int CW = 16,
  parameter int BW = 8
) (
  input  logic          clk_dds,
  input  logic          rst_n,
  input  logic          run,
  input  logic          load,
  input  logic [CW-1:0] h,
  input  logic [BW-1:0] burst,
  output logic          cal,
  output logic          fin
);

  logic [CW-1:0] cnt;
  logic [BW-1:0] pcnt;

  always_ff @(posedge clk_dds) begin
    if (!rst_n || load || !run) begin
      cnt  <= CW'(1);
      cal  <= 1'b0;
      pcnt <= '0;
      fin  <= 1'b0;
    end else if (!fin) begin
      if (cnt == h) begin
        cnt <= CW'(1);
        cal <= ~cal;
        // a falling toggle closes one full period; pcnt never passes burst
        if (cal && (burst != '0)) begin
          pcnt <= pcnt + 1'b1;
          if ((pcnt + 1'b1) == burst)
            fin <= 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cal_div_multi.sv
// Multi-channel programmable divider for NMR calibration tones with burst mode.
// Settings are captured on the IDLE->RUN/DONE transition and held for the whole run.
module cal_div_multi
  import cal_div_multi_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW  = CW_DEF,
  parameter int BW  = BW_DEF
) (
  input  logic              clk_dds,
  input  logic              rst_n,
  input  logic              cal_start,
  input  logic [NCH*CW-1:0] cal_para,
  input  logic [BW-1:0]     burst_len,
  input  logic [NCH-1:0]    ch_en,
  output logic [NCH-1:0]    cal,
  output logic              busy,
  output logic              done,
  output logic              para_err
);

  // state   | meaning
  // IDLE    | outputs low, waiting for cal_start
  // RUN     | active channels dividing
  // DONE    | burst complete, waiting for cal_start to drop

  state_t            state, state_nxt;
  logic [NCH*CW-1:0] para_sh;
  logic [BW-1:0]     burst_sh;
  logic [NCH-1:0]    active_sh, active_now, zero_now, fin, run;
  logic              load, done_nxt, all_fin;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign zero_now[i] = (cal_para[i*CW +: CW] == '0);
    assign run[i]      = (state == ST_RUN) && cal_start && active_sh[i];

    cal_div_chan #(.CW(CW), .BW(BW)) u_chan (
      .clk_dds (clk_dds),
      .rst_n   (rst_n),
      .run     (run[i]),
      .load    (load),
      .h       (para_sh[i*CW +: CW]),
      .burst   (burst_sh),
      .cal     (cal[i]),
      .fin     (fin[i])
    );
  end

  assign active_now = ch_en & ~zero_now;
  assign all_fin    = &(fin | ~active_sh);
  assign busy       = (state == ST_RUN);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cal_start) begin
          load = 1'b1;
          if (active_now == '0) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // abort takes priority over a coincident burst completion
        if (!cal_start) begin
          state_nxt = ST_IDLE;
        end else if ((burst_sh != '0) && all_fin) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
        end
      end
      ST_DONE: begin
        if (!cal_start)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_dds) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      done      <= 1'b0;
      para_err  <= 1'b0;
      para_sh   <= '0;
      burst_sh  <= '0;
      active_sh <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (load) begin
        para_sh   <= cal_para;
        burst_sh  <= burst_len;
        active_sh <= active_now;
        para_err  <= |(ch_en & zero_now);
      end
    end
  end

endmodule

// File: tb/tb_cal_div_multi.sv
// Self-checking bench for cal_div_multi against a closed-form waveform model.
module tb_cal_div_multi;

  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int BW  = 8;

  logic              clk_dds = 1'b0;
  logic              rst_n = 1'b0;
  logic              cal_start = 1'b0;
  logic [NCH*CW-1:0] cal_para = '0;
  logic [BW-1:0]     burst_len = '0;
  logic [NCH-1:0]    ch_en = '0;
  logic [NCH-1:0]    cal;
  logic              busy, done, para_err;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state for the current run
  int         m_h [NCH];
  int         m_b;
  logic [3:0] m_act;
  int         m_jdone;
  logic       m_perr = 1'b0;

  cal_div_multi #(.NCH(NCH), .CW(CW), .BW(BW)) dut (
    .clk_dds   (clk_dds),
    .rst_n     (rst_n),
    .cal_start (cal_start),
    .cal_para  (cal_para),
    .burst_len (burst_len),
    .ch_en     (ch_en),
    .cal       (cal),
    .busy      (busy),
    .done      (done),
    .para_err  (para_err)
  );

  always #5 clk_dds = ~clk_dds;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_dds);
    #1;
  endtask

  function automatic logic [6:0] obs_vec();
    return {cal, busy, done, para_err};
  endfunction

  // Expected {cal,busy,done,para_err} sampled after edge k+j; cal_start low at edge k+L.
  function automatic logic [6:0] exp_vec(input int j, input int L);
    logic [3:0] c;
    logic       b, d;
    c = '0; b = 1'b0; d = 1'b0;
    if (j < L) begin
      b = (m_act != 0) && (j < m_jdone);
      d = (j == m_jdone);
      for (int i = 0; i < NCH; i++)
        if (m_act[i] && (j < m_jdone) && !(m_b != 0 && j >= 2 * m_b * m_h[i]) &&
            (((j / m_h[i]) % 2) == 1))
          c[i] = 1'b1;
    end
    return {c, b, d, m_perr};
  endfunction

  task automatic run_case(input string name, input logic [63:0] para, input logic [7:0] blen,
                          input logic [3:0] en, input int L, input bit scramble);
    logic [15:0] h;
    int          mx;
    cal_start = 1'b0;
    step();
    chk($sformatf("%s idle", name), 32'(obs_vec()), {25'd0, 6'd0, m_perr});
    cal_para  = para;
    burst_len = blen;
    ch_en     = en;
    m_b  = int'(blen);
    m_perr = 1'b0;
    mx   = 0;
    for (int i = 0; i < NCH; i++) begin
      h = para[i*CW +: CW];
      m_h[i]   = int'(h);
      m_act[i] = en[i] && (h != 0);
      if (en[i] && h == 0) m_perr = 1'b1;
      if (m_act[i] && 2 * m_b * m_h[i] > mx) mx = 2 * m_b * m_h[i];
    end
    if (m_act == 0)    m_jdone = 0;
    else if (m_b == 0) m_jdone = 1 << 30;
    else               m_jdone = mx + 1;
    cal_start = 1'b1;
    for (int j = 0; j <= L; j++) begin
      if (j == L) cal_start = 1'b0;
      if (j > 0 && scramble) begin
        cal_para  = {$urandom, $urandom};
        burst_len = BW'($urandom);
        ch_en     = NCH'($urandom);
      end
      step();
      chk($sformatf("%s j=%0d", name, j), 32'(obs_vec()), 32'(exp_vec(j, L)));
    end
  endtask

  initial begin
    logic [63:0] p;
    logic [3:0]  e;
    logic [7:0]  bl;

    step();
    step();
    chk("reset", 32'(obs_vec()), 32'd0);
    rst_n = 1'b1;

    run_case("t1_h3", {48'd0, 16'd3}, 8'd0, 4'b0001, 20, 1'b0);
    run_case("t2_burst", {32'd0, 16'd5, 16'd1}, 8'd2, 4'b0011, 30, 1'b0);
    run_case("t3_mid", {48'd0, 16'd3}, 8'd0, 4'b0001, 15, 1'b1);
    run_case("t3_restart", {48'd0, 16'd7}, 8'd0, 4'b0001, 30, 1'b0);
    run_case("t4_perr", {16'd0, 16'd0, 16'd0, 16'd2}, 8'd0, 4'b0101, 12, 1'b0);
    run_case("t4_empty", {16'd0, 16'd0, 16'd0, 16'd2}, 8'd0, 4'b0100, 4, 1'b0);
    run_case("t5_abort_mid", {48'd0, 16'd2}, 8'd3, 4'b0001, 7, 1'b0);
    run_case("t5_abort_fin", {48'd0, 16'd2}, 8'd3, 4'b0001, 12, 1'b0);
    run_case("t5_abort_done", {48'd0, 16'd2}, 8'd3, 4'b0001, 13, 1'b0);

    // reset asserted mid-run clears everything including para_err
    cal_start = 1'b0;
    step();
    cal_para  = {32'd0, 16'd0, 16'd4};
    ch_en     = 4'b0011;
    burst_len = 8'd0;
    cal_start = 1'b1;
    for (int j = 0; j < 7; j++) step();
    chk("pre_rst cal", 32'(cal), 32'd1);
    chk("pre_rst perr", 32'(para_err), 32'd1);
    rst_n = 1'b0;
    cal_start = 1'b0;
    step();
    chk("mid_rst", 32'(obs_vec()), 32'd0);
    rst_n  = 1'b1;
    m_perr = 1'b0;

    for (int r = 0; r < 40; r++) begin
      p = '0;
      for (int i = 0; i < NCH; i++) p[i*CW +: CW] = CW'($urandom_range(0, 6));
      e  = NCH'($urandom);
      bl = BW'($urandom_range(0, 3));
      run_case($sformatf("rnd%0d", r), p, bl, e, int'($urandom_range(1, 60)),
               1'($urandom_range(0, 1)));
    end

    run_case("t6_long", {48'd0, 16'hFFFF}, 8'd0, 4'b0001, 65537, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
